// File: rtl/alu_seq_if.sv
`default_nettype none
// ============================================================================
// Module   : alu_seq_if
// Purpose  : Request/response bundle between the control unit and alu_seq.
// Revision : 1.0
// ============================================================================

interface alu_seq_if #(
    parameter int N = 64
);
    logic         start;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic [3:0]   ALUcontrol;
    logic         busy;
    logic         done;
    logic [N-1:0] result;
    logic         zero;

    modport master (
        output start, a, b, ALUcontrol,
        input  busy, done, result, zero
    );

    modport slave (
        input  start, a, b, ALUcontrol,
        output busy, done, result, zero
    );
endinterface

`default_nettype wire

// File: rtl/alu_seq.sv
`default_nettype none
// ============================================================================
// Module   : alu_seq
// Purpose  : Registered LEGv8 ALU; single-cycle logic/arith ops plus N-cycle
//            shift-add multiply and restoring divide behind start/busy/done.
// Revision : 1.0
// ============================================================================

module alu_seq #(
    parameter int N = 64
) (
    input  logic      clk,
    input  logic      reset,
    alu_seq_if.slave  bus
);

    localparam int            C_CW       = $clog2(N + 1);
    localparam logic [C_CW-1:0] C_CNT_LOAD = C_CW'(N);
    localparam logic [C_CW-1:0] C_CNT_LAST = C_CW'(1);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [C_CW-1:0] cnt_q, cnt_d;
    logic [1:0]      op_q, op_d;
    logic [2*N-1:0]  acc_q, acc_d;
    logic [N-1:0]    opb_q, opb_d;
    logic [N-1:0]    result_q, result_d;
    logic            zero_q, zero_d;
    logic            done_q, done_d;

    logic [N-1:0]    w_alu;
    logic            w_is_iter;
    logic [N:0]      w_mul_sum;
    logic [2*N-1:0]  w_mul_next;
    logic [N:0]      w_div_shift;
    logic [N-1:0]    w_div_diff;
    logic            w_div_ge;
    logic [2*N-1:0]  w_div_next;
    logic [2*N-1:0]  w_step;
    logic [N-1:0]    w_fin;

    assign w_is_iter = (bus.ALUcontrol[3:2] == 2'b10);

    always_comb begin
        w_alu = '1;
        case (bus.ALUcontrol)
            4'b0000: w_alu = bus.a & bus.b;
            4'b0001: w_alu = bus.a | bus.b;
            4'b0010: w_alu = bus.a + bus.b;
            4'b0110: w_alu = bus.a - bus.b;
            4'b0111: w_alu = bus.b;
            default: w_alu = '1;
        endcase
    end

    // Multiply: acc = {partial high, remaining multiplier bits}; add then shift right.
    assign w_mul_sum  = {1'b0, acc_q[2*N-1:N]} + (acc_q[0] ? {1'b0, opb_q} : {(N+1){1'b0}});
    assign w_mul_next = {w_mul_sum, acc_q[N-1:1]};

    // Divide: acc = {remainder, dividend/quotient}; the shifted remainder needs N+1 bits.
    assign w_div_shift = acc_q[2*N-1:N-1];
    assign w_div_ge    = (w_div_shift >= {1'b0, opb_q});
    assign w_div_diff  = w_div_shift[N-1:0] - opb_q;
    assign w_div_next  = w_div_ge ? {w_div_diff, acc_q[N-2:0], 1'b1}
                                  : {w_div_shift[N-1:0], acc_q[N-2:0], 1'b0};

    assign w_step = op_q[1] ? w_div_next : w_mul_next;

    // A zero divisor leaves all-ones in the quotient half, so UDIV is forced to 0.
    always_comb begin
        w_fin = w_step[N-1:0];
        case (op_q)
            2'b00:   w_fin = w_step[N-1:0];
            2'b01:   w_fin = w_step[2*N-1:N];
            2'b10:   w_fin = (opb_q == '0) ? '0 : w_step[N-1:0];
            default: w_fin = w_step[2*N-1:N];
        endcase
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        acc_d    = acc_q;
        opb_d    = opb_q;
        result_d = result_q;
        zero_d   = zero_q;
        done_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    if (w_is_iter) begin
                        state_d = RUN;
                        cnt_d   = C_CNT_LOAD;
                        op_d    = bus.ALUcontrol[1:0];
                        opb_d   = bus.b;
                        acc_d   = {{N{1'b0}}, bus.a};
                    end else begin
                        result_d = w_alu;
                        zero_d   = (w_alu == '0);
                        done_d   = 1'b1;
                    end
                end
            end
            RUN: begin
                acc_d = w_step;
                cnt_d = cnt_q - C_CNT_LAST;
                if (cnt_q == C_CNT_LAST) begin
                    state_d  = IDLE;
                    result_d = w_fin;
                    zero_d   = (w_fin == '0);
                    done_d   = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            op_q     <= '0;
            acc_q    <= '0;
            opb_q    <= '0;
            result_q <= '0;
            zero_q   <= 1'b1;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            acc_q    <= acc_d;
            opb_q    <= opb_d;
            result_q <= result_d;
            zero_q   <= zero_d;
            done_q   <= done_d;
        end
    end

    assign bus.busy   = (state_q == RUN);
    assign bus.done   = done_q;
    assign bus.result = result_q;
    assign bus.zero   = zero_q;

endmodule

`default_nettype wire

// File: doc/alu_seq.md
# alu_seq

Parametrised, registered successor to the single-cycle datapath ALU for the LEGv8 core. It keeps the existing single-cycle operation encodings (AND, OR, ADD, SUB, pass-B) with a one-cycle registered latency, and adds iterative unsigned multiply and divide (MUL, UMULH, UDIV, UREM) that complete in N cycles. A start/busy/done handshake lets the control unit stall the pipeline while a long operation runs.

## Interface
- N, default 64: operand/result width in bits; legal values N ≥ 2.
- clk  in  1  system clock, all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset; clears all state immediately when low.
- start  in  1  request; sampled only when busy=0.
- a  in  N  first operand, captured on the accepting edge.
- b  in  N  second operand, captured on the accepting edge.
- ALUcontrol  in  4  operation select, captured on the accepting edge.
- busy  out  1  high while an iterative operation is in progress.
- done  out  1  one-cycle pulse; result/zero are valid for the completed operation.
- result  out  N  registered result; holds until the next completion.
- zero  out  1  registered; 1 iff result == 0.

## Operation
- Encodings: 0000 a&b; 0001 a|b; 0010 a+b (mod 2^N); 0110 a−b (mod 2^N); 0111 b; 1000 MUL = low N bits of a×b; 1001 UMULH = high N bits of unsigned a×b; 1010 UDIV = a/b unsigned; 1011 UREM = a mod b unsigned; any other = all ones (single-cycle class).
- Single-cycle class (0000, 0001, 0010, 0110, 0111, undefined): result computed from the inputs present on the accepting edge and registered on that edge.
- Iterative class (1000–1011):
  - Multiply is radix-2 shift-add over a 2N-bit product register.
  - Divide is restoring, one quotient bit per step, with a 2N-bit remainder/quotient register.
  - Operands and op are latched on accept; later changes to a, b and ALUcontrol have no effect.
- Divide by zero (b=0): UDIV returns 0 and UREM returns a (ARM semantics). It still takes the full N cycles.
- States:
  - IDLE: busy=0.
  - RUN: busy=1; a down-counter of width $clog2(N+1) is loaded with N on accept.
- IDLE, start=1, single-cycle op: result, zero and done=1 are written on that edge; remain in IDLE.
- IDLE, start=1, iterative op: go to RUN with the counter set to N.
- RUN: each edge performs one step and decrements the counter.
  - On the edge where the counter reaches 0: write result and zero, set done=1, return to IDLE.
- start while busy=1 is ignored; it is neither queued nor an error.
- done is cleared on every edge that does not complete an operation.
- result and zero change only on a completing edge.

## Timing
- Reset values: busy=0, done=0, result=0, zero=1, state IDLE, counter 0, internal registers 0.
- Reset asserted mid-RUN aborts the operation immediately. No done is produced. Outputs return to reset values.
- Single-cycle latency: start accepted at edge k gives done=1 and a valid result in the cycle after edge k.
- Iterative latency: start accepted at edge k.
  - busy=1 in the N cycles following edges k..k+N−1.
  - done=1 with a valid result in the cycle following edge k+N.
- Back-to-back: start in the done cycle is accepted (busy is 0 then).
  - Single-cycle throughput: one op per cycle.
  - Iterative throughput: one op per N cycles.
- done and busy are never high in the same cycle.

## Test plan
- Reset low mid-MUL (N=64, after 10 steps), release, then idle 70 cycles -> no done pulse; result=0, zero=1, busy=0 throughout.
- N=64, back-to-back single-cycle ops: ADD a=5,b=3; then SUB a=3,b=3; then op 0101 -> done on three consecutive cycles with result 8/zero=0, then 0/zero=1, then FFFF_FFFF_FFFF_FFFF.
- N=64, MUL a=FFFF_FFFF_FFFF_FFFF, b=2, then UMULH same operands:
  - MUL gives FFFF_FFFF_FFFF_FFFE; UMULH gives 1.
  - busy high exactly 64 cycles each, done 64 cycles after the accepting edge.
  - start pulses during busy are ignored.
- N=64, UDIV a=100,b=7 -> 14; UREM a=100,b=7 -> 2. Change a, b and ALUcontrol every cycle while busy -> results unaffected.
- N=8, divide by zero and edge values:
  - UDIV 200/0 -> 0 with zero=1.
  - UREM 200/0 -> 200.
  - MUL 16×16 -> 0; UMULH 16×16 -> 1.
  - Latency 8 cycles each.
- Randomised N=16 sweep, 10k ops, random start gaps -> every result matches the reference model. Exactly one done per accepted start, at the specified latency.
